// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller for the 5-stage pipeline. It takes the EX/MEM
// pipeline register outputs, runs a req/ack handshake with a variable-latency
// data memory, and owns the MEM/WB pipeline register. The memory stage and
// everything upstream is stalled until the access completes. Each load/store
// is issued exactly once, even while an external freeze (stall_in) holds the
// memory stage after the memory has already answered.
//
// Optional feature: define DM_TIMEOUT_EN to enable the access timeout. After
// TIMEOUT_CYC request cycles without an ack the access is force-completed:
// a load returns 0, a store is dropped, and the sticky dm_err flag is set.
// With DM_TIMEOUT_EN undefined, WAIT lasts until the ack and dm_err is 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   *_M inputs          EX/MEM register fields (address, store data, PC+4,
//                       HI/LO, write address, control bits)
//   stall_in            external freeze of the memory stage and upstream
//   dm_ack, dm_rdata    memory handshake response / read data
//   dm_req, dm_we,
//   dm_addr, dm_wdata   memory request side
//   stall_M             hold EX/MEM and all upstream registers
//   dm_err              sticky timeout flag
//   *_W outputs         MEM/WB register contents
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] wd_dm_M,
  input  logic [31:0] pc_plus4_M,
  input  logic [63:0] hilo_d_M,
  input  logic [4:0]  rf_wa_M,
  input  logic        dm2reg_M,
  input  logic        we_dm_M,
  input  logic        we_reg_M,
  input  logic        we_hilo_M,
  input  logic        jal_M,
  input  logic        stall_in,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        stall_M,
  output logic        dm_err,
  output logic [31:0] rd_dm_W,
  output logic [31:0] alu_out_W,
  output logic [31:0] pc_plus4_W,
  output logic [63:0] hilo_d_W,
  output logic [4:0]  rf_wa_W,
  output logic        dm2reg_W,
  output logic        we_reg_W,
  output logic        we_hilo_W,
  output logic        jal_W
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] rdata_q;
  logic        access_m;
  logic        complete;
  logic        timeout;
  logic [31:0] ld_data;

  assign access_m = dm2reg_M | we_dm_M;

  // Upstream registers hold while stalled, so these stay stable for the
  // whole access without local copies.
  assign dm_addr  = alu_out_M;
  assign dm_wdata = wd_dm_M;
  assign dm_we    = we_dm_M;

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  // An ack in the last allowed cycle still wins over the timeout.
  assign timeout = (state_reg == WAIT) && !dm_ack &&
                   (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
  assign dm_err  = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && access_m && !complete) begin
        cnt_reg <= CNT_W'(1);
      end else if (state_reg == WAIT && !complete) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign dm_err  = 1'b0;
`endif

  always_comb begin
    dm_req   = 1'b0;
    complete = 1'b0;
    case (state_reg)
      IDLE: begin
        dm_req   = access_m;
        complete = access_m & dm_ack;
      end
      WAIT: begin
        dm_req   = 1'b1;
        complete = dm_ack | timeout;
      end
      default: begin
        // HOLD: access already finished; never re-request it.
        dm_req   = 1'b0;
        complete = 1'b0;
      end
    endcase
    if (rst) begin
      dm_req = 1'b0;
    end
  end

  assign stall_M = stall_in |
                   ((state_reg != HOLD) & access_m & ~complete);

  // Data that a load would hand to writeback this cycle.
  assign ld_data = (state_reg == HOLD) ? rdata_q :
                   (timeout ? 32'h0 : dm_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rdata_q    <= 32'h0;
      rd_dm_W    <= 32'h0;
      alu_out_W  <= 32'h0;
      pc_plus4_W <= 32'h0;
      hilo_d_W   <= 64'h0;
      rf_wa_W    <= 5'd0;
      dm2reg_W   <= 1'b0;
      we_reg_W   <= 1'b0;
      we_hilo_W  <= 1'b0;
      jal_W      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, WAIT: begin
          if (complete) begin
            // Completed under freeze: park the data so the request is
            // not repeated while the stage is held.
            if (stall_in) begin
              rdata_q   <= ld_data;
              state_reg <= HOLD;
            end else begin
              state_reg <= IDLE;
            end
          end else if (access_m) begin
            state_reg <= WAIT;
          end
        end
        default: begin
          if (!stall_in) begin
            state_reg <= IDLE;
          end
        end
      endcase

      if (stall_M) begin
        // Bubble: kill the side-effect bits, leave the data fields alone.
        dm2reg_W  <= 1'b0;
        we_reg_W  <= 1'b0;
        we_hilo_W <= 1'b0;
        jal_W     <= 1'b0;
      end else begin
        rd_dm_W    <= dm2reg_M ? ld_data : 32'h0;
        alu_out_W  <= alu_out_M;
        pc_plus4_W <= pc_plus4_M;
        hilo_d_W   <= hilo_d_M;
        rf_wa_W    <= rf_wa_M;
        dm2reg_W   <= dm2reg_M;
        we_reg_W   <= we_reg_M;
        we_hilo_W  <= we_hilo_M;
        jal_W      <= jal_M;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

`ifdef DM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_M, wd_dm_M, pc_plus4_M;
  logic [63:0] hilo_d_M;
  logic [4:0]  rf_wa_M;
  logic        dm2reg_M, we_dm_M, we_reg_M, we_hilo_M, jal_M;
  logic        stall_in, dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_req, dm_we, stall_M, dm_err;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] rd_dm_W, alu_out_W, pc_plus4_W;
  logic [63:0] hilo_d_W;
  logic [4:0]  rf_wa_W;
  logic        dm2reg_W, we_reg_W, we_hilo_W, jal_W;

  mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .alu_out_M(alu_out_M), .wd_dm_M(wd_dm_M), .pc_plus4_M(pc_plus4_M),
    .hilo_d_M(hilo_d_M), .rf_wa_M(rf_wa_M),
    .dm2reg_M(dm2reg_M), .we_dm_M(we_dm_M), .we_reg_M(we_reg_M),
    .we_hilo_M(we_hilo_M), .jal_M(jal_M),
    .stall_in(stall_in), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .stall_M(stall_M), .dm_err(dm_err),
    .rd_dm_W(rd_dm_W), .alu_out_W(alu_out_W), .pc_plus4_W(pc_plus4_W),
    .hilo_d_W(hilo_d_W), .rf_wa_W(rf_wa_W),
    .dm2reg_W(dm2reg_W), .we_reg_W(we_reg_W), .we_hilo_W(we_hilo_W),
    .jal_W(jal_W)
  );

  always #5 clk = ~clk;

  // One instruction: memory-stage fields plus how the environment behaves.
  // ack_at: cycle index (from issue) of dm_ack; stall_cyc: stall_in is high
  // for cycle indices 0..stall_cyc-1.
  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  wa;
    logic        we_reg;
    int          ack_at;
    int          stall_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  wa;
    logic        we_reg;
    logic        dm2reg;
  } wb_t;

  wb_t  sb[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input vec_t v, input int idx);
    alu_out_M  = v.addr;
    wd_dm_M    = v.wdata;
    pc_plus4_M = 32'h100 + 32'(idx * 4);
    hilo_d_M   = {v.addr, v.wdata};
    rf_wa_M    = v.wa;
    dm2reg_M   = v.ld;
    we_dm_M    = v.st;
    we_reg_M   = v.we_reg;
    we_hilo_M  = 1'b0;
    jal_M      = 1'b0;
  endtask

  task automatic check_w_zero();
    chk("rst rd_dm_W", 64'(rd_dm_W), 64'h0);
    chk("rst alu_out_W", 64'(alu_out_W), 64'h0);
    chk("rst pc_plus4_W", 64'(pc_plus4_W), 64'h0);
    chk("rst hilo_d_W", hilo_d_W, 64'h0);
    chk("rst rf_wa_W", 64'(rf_wa_W), 64'h0);
    chk("rst ctl_W", 64'({dm2reg_W, we_reg_W, we_hilo_W, jal_W}), 64'h0);
  endtask

  task automatic run_instr(input vec_t v, input int idx);
    logic acc, exp_req, exp_stall;
    wb_t  e;
    bit   done;
    int   k;
    drive_m(v, idx);
    acc  = v.ld | v.st;
    done = 0;
    k    = 0;
    while (!done && k < 40) begin
      dm_ack   = (k == v.ack_at);
      dm_rdata = (k == v.ack_at) ? v.rdata : $urandom;
      stall_in = (k < v.stall_cyc);
      #2;
      exp_req   = acc && (k <= v.ack_at);
      exp_stall = stall_in || (acc && (k < v.ack_at));
      chk("dm_req", 64'(dm_req), 64'(exp_req));
      chk("stall_M", 64'(stall_M), 64'(exp_stall));
      if (exp_req) begin
        chk("dm_we", 64'(dm_we), 64'(v.st));
        chk("dm_addr", 64'(dm_addr), 64'(v.addr));
        chk("dm_wdata", 64'(dm_wdata), 64'(v.wdata));
      end
      if (!exp_stall) begin
        e.rd     = v.ld ? v.rdata : 32'h0;
        e.alu    = v.addr;
        e.pc     = 32'h100 + 32'(idx * 4);
        e.wa     = v.wa;
        e.we_reg = v.we_reg;
        e.dm2reg = v.ld;
        sb.push_back(e);
        done = 1;
      end
      step();
      if (exp_stall) begin
        chk("bubble we_reg_W", 64'(we_reg_W), 64'h0);
        chk("bubble dm2reg_W", 64'(dm2reg_W), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("rd_dm_W", 64'(rd_dm_W), 64'(e.rd));
        chk("alu_out_W", 64'(alu_out_W), 64'(e.alu));
        chk("pc_plus4_W", 64'(pc_plus4_W), 64'(e.pc));
        chk("rf_wa_W", 64'(rf_wa_W), 64'(e.wa));
        chk("we_reg_W", 64'(we_reg_W), 64'(e.we_reg));
        chk("dm2reg_W", 64'(dm2reg_W), 64'(e.dm2reg));
        $display("txn %0d: ld=%0b st=%0b addr=%h rd_dm_W=%h rf_wa_W=%0d cycles=%0d",
                 txn, v.ld, v.st, v.addr, rd_dm_W, rf_wa_W, k + 1);
        txn++;
      end
      k++;
    end
    if (!done) chk("completion bound", 64'h0, 64'h1);
    dm_ack = 1'b0;
  endtask

  initial begin
    //         ld    st    addr          wdata         rdata         wa     we  ack stall
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h1234_5678, 5'd8,  1'b1, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'h0,         5'd0,  1'b0, 3, 0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0,         32'hCAFE_F00D, 5'd9,  1'b1, 0, 5};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         32'h1111_2222, 5'd10, 1'b1, 1, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_4004, 32'h0,         32'h3333_4444, 5'd11, 1'b1, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_00AA, 32'h0,         32'hFFFF_FFFF, 5'd12, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_5010, 32'h0,         32'h5555_6666, 5'd13, 1'b1, 2, 4};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_6000, 32'hA5A5_5A5A, 32'h0,         5'd0,  1'b0, 3, 1};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_00BB, 32'h0,         32'h0,         5'd14, 1'b1, 0, 2};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_7000, 32'h0,         32'h7777_8888, 5'd15, 1'b1, 3, 0};

    // Reset with a load presented: request must stay low while rst=1.
    rst = 1'b1;
    drive_m(vecs[0], 0);
    stall_in = 1'b0;
    dm_ack   = 1'b0;
    dm_rdata = 32'h0;
    step();
    #2;
    chk("dm_req in reset", 64'(dm_req), 64'h0);
    check_w_zero();
    chk("dm_err reset", 64'(dm_err), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i], i);
    end

    // Reset in the middle of a WAIT aborts the access.
    drive_m('{1'b1, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 5'd16, 1'b1, 0, 0}, 20);
    dm_ack   = 1'b0;
    stall_in = 1'b0;
    #2;
    chk("abort issue dm_req", 64'(dm_req), 64'h1);
    step();
    #2;
    chk("abort wait dm_req", 64'(dm_req), 64'h1);
    chk("abort wait stall_M", 64'(stall_M), 64'h1);
    rst = 1'b1;
    #1;
    chk("abort rst dm_req", 64'(dm_req), 64'h0);
    step();
    check_w_zero();
    rst      = 1'b0;
    dm2reg_M = 1'b0;
    we_dm_M  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("post-abort dm_req", 64'(dm_req), 64'h0);
      chk("post-abort stall_M", 64'(stall_M), 64'h0);
      step();
    end
    $display("txn %0d: reset during WAIT, access aborted", txn);
    txn++;

    // Recovery after the abort.
    run_instr('{1'b1, 1'b0, 32'h0000_9000, 32'h0, 32'h0BAD_C0DE, 5'd17, 1'b1, 0, 0}, 21);

`ifdef DM_TIMEOUT_EN
    // No ack at all: TO request cycles, load returns zero, sticky error.
    chk("dm_err before timeout", 64'(dm_err), 64'h0);
    drive_m('{1'b1, 1'b0, 32'h0000_A000, 32'h0, 32'h0, 5'd20, 1'b1, 0, 0}, 22);
    dm_ack   = 1'b0;
    stall_in = 1'b0;
    for (int k = 0; k < TO; k++) begin
      dm_rdata = $urandom;
      #2;
      chk("timeout dm_req", 64'(dm_req), 64'h1);
      chk("timeout stall_M", 64'(stall_M), 64'(k < TO - 1));
      step();
    end
    chk("timeout rd_dm_W", 64'(rd_dm_W), 64'h0);
    chk("timeout we_reg_W", 64'(we_reg_W), 64'h1);
    chk("timeout rf_wa_W", 64'(rf_wa_W), 64'd20);
    chk("timeout dm_err", 64'(dm_err), 64'h1);
    dm2reg_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("after timeout dm_req", 64'(dm_req), 64'h0);
      step();
    end
    chk("dm_err sticky", 64'(dm_err), 64'h1);
    $display("txn %0d: timeout load, rd_dm_W=%h dm_err=%0b", txn, rd_dm_W, dm_err);
    txn++;
`else
    chk("dm_err tied low", 64'(dm_err), 64'h0);
`endif

    chk("scoreboard empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
